emmc_ddr_dat_rx: RTL and testbench
==================================

// Module: emmc_ddr_dat_rx
// PURPOSE
//  Receive side of the DDR DAT path: captures DAT lines on both sd_clk edges and detects the start bit.
//  Assembles rise/fall sample pairs into payload words and checks one CRC16 per line per edge.
//  Verifies the end bit. Sits between the DAT pads and the read-data FIFO of the sd/eMMC controller.
//  It is the counterpart of the controller's DDR output register path.
// PARAMETERS
//  DAT_W        4     DAT lane count (1, 4 or 8)
//  BLK_W        12    width of blk_size_i, in bytes
//  TIMEOUT_CYC  1024  sd_clk cycles to wait for a start bit before flagging timeout
// PORTS
//  sd_clk        in   1        card clock; rising and falling edges both used for capture
//  rst_n         in   1        async active-low reset
//  dat_i         in   DAT_W    DAT pad inputs
//  start_i       in   1        arm receiver; sampled only in IDLE
//  abort_i       in   1        synchronous abort to IDLE, any state
//  blk_size_i    in   BLK_W    payload bytes; sampled with start_i
//  data_o        out  2*DAT_W  {rise sample, fall sample}; rise in the MSBs
//  data_valid_o  out  1        data_o holds one payload pair
//  busy_o        out  1        state != IDLE
//  done_o        out  1        one-cycle pulse at block end
//  crc_err_o     out  1        sticky until next start_i: any CRC remainder nonzero
//  end_err_o     out  1        sticky until next start_i: end bit not all-ones
//  timeout_o     out  1        sticky until next start_i: no start bit in TIMEOUT_CYC
// BEHAVIOUR
//  Reset (async, rst_n=0): all flops clear; FSM=IDLE; all outputs 0.
//  Capture:
//   - rise_q <= dat_i @posedge N; fall_q <= dat_i @negedge N.
//   - pair <= {rise_q, fall_q} @posedge N+1.
//   - data_o and data_valid_o register @posedge N+2, so latency is 2 cycles from rising edge N.
//  FSM (transitions at posedge, evaluated on pair):
//   IDLE   : start_i=1 -> WAIT. Latch blk_size_i; clear sticky flags, CRCs, counters.
//            blk_size_i=0 -> DONE directly, no data, no flags.
//   WAIT   : pair all-zero (start bit) -> DATA.
//            cycle count reaches TIMEOUT_CYC-1 -> set timeout_o -> DONE.
//   DATA   : data_valid_o=1 for each pair; feed each of the 2*DAT_W bit streams to its own CRC16.
//            After blk_size*8/(2*DAT_W) pairs -> CRC.
//   CRC    : 16 pairs, not output; feed into the same CRC engines -> END.
//   END    : pair != all-ones -> set end_err_o. Any remainder != 0 -> set crc_err_o. -> DONE.
//   DONE   : done_o=1 for one cycle -> IDLE.
//  CRC16: poly x^16+x^12+x^5+1, init 0x0000, MSB first.
//   - One engine per line per edge: 2*DAT_W engines.
//   - A correct block leaves every remainder at 0.
//  Arithmetic: pair counter width BLK_W+3. blk_size*8 must be a multiple of 2*DAT_W, else end_err_o=1.
//  Boundaries:
//   - abort_i beats every other event, done_o included. Next cycle: IDLE, no done_o, flags kept.
//   - start_i while busy is ignored.
//   - start_i coincident with done_o is ignored; the FSM must return to IDLE first.
//   - rst_n low mid-block: immediate IDLE, outputs 0, the partial block is lost.
//   - Pairs outside DATA never raise data_valid_o.
// CONFIGURATION
//  EMMC_DDR_RX_LANE_ERR_EN defined:
//   - adds output crc_lane_err_o[2*DAT_W-1:0], one bit per engine.
//   - Each bit is sticky, set in END when its remainder != 0, cleared on start_i.
//   - Bit 2*DAT_W-1-i = rise of line DAT_W-1-i; lower half = fall lanes.
//  Not defined: port absent; only the ORed crc_err_o exists.
// TESTING  (DAT_W=4 unless noted)
//  1. blk_size=4; start, 4 pairs 0x12,0x34,0x56,0x78, valid CRC, end=0xFF
//     -> 4 data_valid_o with the same values; done_o once; all flags 0.
//  2. Same block with one CRC bit flipped on DAT2 fall -> crc_err_o=1.
//     With EMMC_DDR_RX_LANE_ERR_EN: crc_lane_err_o=8'b0000_0100.
//  3. start_i with DAT held 0xF for 1024 cycles -> timeout_o=1, done_o, no data_valid_o.
//  4. End pair 0xEF -> end_err_o=1, crc_err_o=0, done_o once.
//  5. abort_i in DATA after 2 pairs -> busy_o=0 next cycle.
//     No done_o. Next start_i receives a clean block.
//  6. rst_n low in CRC state -> all outputs 0 asynchronously.
//     DAT_W=8, blk_size=512 -> 256 valid pairs, flags 0.

Source files
------------

// File: rtl/emmc_ddr_dat_rx.sv
// DDR DAT receive path: dual-edge capture, start-bit search, payload pairs, per-lane CRC16, end bit.
// Optional per-engine CRC error vector when EMMC_DDR_RX_LANE_ERR_EN is defined.
`timescale 1ns/1ps
module emmc_ddr_dat_rx #(
  parameter int DAT_W       = 4,
  parameter int BLK_W       = 12,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               sd_clk,
  input  logic               rst_n,
  input  logic [DAT_W-1:0]   dat_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [BLK_W-1:0]   blk_size_i,
  output logic [2*DAT_W-1:0] data_o,
  output logic               data_valid_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               crc_err_o,
  output logic               end_err_o,
  output logic               timeout_o
`ifdef EMMC_DDR_RX_LANE_ERR_EN
  ,
  output logic [2*DAT_W-1:0] crc_lane_err_o
`endif
);

  localparam int PW    = 2 * DAT_W;
  localparam int SH    = $clog2(PW);
  localparam int PC_W  = BLK_W + 3;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W = (PC_W > TO_W) ? PC_W : TO_W;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_CRC, S_END, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DAT_W-1:0]  rise_q, fall_q;
  logic [PW-1:0]     pair_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [PC_W-1:0]   npairs_q, npairs_d;
  logic [PC_W-1:0]   blk_bits;
  logic [PW-1:0]     data_q;
  logic              valid_q, valid_d;
  logic              done_q;
  logic              crc_err_q, end_err_q, timeout_q;
  logic              clr, crc_en, set_timeout, set_end;
  logic [PW-1:0]     lane_set, crc_nz;

  assign blk_bits = {blk_size_i, 3'b000};
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) rise_q <= '0;
    else        rise_q <= dat_i;
  end

  always_ff @(negedge sd_clk or negedge rst_n) begin
    if (!rst_n) fall_q <= '0;
    else        fall_q <= dat_i;
  end

  // One CRC16 engine per bit of the pair: upper half rise lanes, lower half fall lanes.
  for (genvar gi = 0; gi < PW; gi++) begin : g_crc
    logic [15:0] crc_q;
    logic        fb;
    assign fb = crc_q[15] ^ pair_q[gi];
    always_ff @(posedge sd_clk or negedge rst_n) begin
      if (!rst_n)      crc_q <= '0;
      else if (clr)    crc_q <= '0;
      else if (crc_en) crc_q <= {crc_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    assign crc_nz[gi] = |crc_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    npairs_d    = npairs_q;
    clr         = 1'b0;
    crc_en      = 1'b0;
    valid_d     = 1'b0;
    set_timeout = 1'b0;
    set_end     = 1'b0;
    lane_set    = '0;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          clr      = 1'b1;
          cnt_d    = '0;
          npairs_d = blk_bits >> SH;
          // A block that does not fill whole pairs can never end cleanly.
          set_end  = |blk_bits[SH-1:0];
          state_d  = (blk_size_i == '0) ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (pair_q == '0) begin
            cnt_d   = '0;
            state_d = (npairs_q == '0) ? S_CRC : S_DATA;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            set_timeout = 1'b1;
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_DATA: begin
          valid_d = 1'b1;
          crc_en  = 1'b1;
          if (cnt_inc == CNT_W'(npairs_q)) begin
            cnt_d   = '0;
            state_d = S_CRC;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_CRC: begin
          crc_en = 1'b1;
          if (cnt_q == CNT_W'(15)) begin
            cnt_d   = '0;
            state_d = S_END;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_END: begin
          set_end  = (pair_q != '1);
          lane_set = crc_nz;
          state_d  = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pair_q    <= '0;
      cnt_q     <= '0;
      npairs_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pair_q    <= {rise_q, fall_q};
      cnt_q     <= cnt_d;
      npairs_q  <= npairs_d;
      valid_q   <= valid_d;
      if (valid_d) data_q <= pair_q;
      done_q    <= (state_d == S_DONE);
      crc_err_q <= (crc_err_q & ~clr) | (|lane_set);
      end_err_q <= (end_err_q & ~clr) | set_end;
      timeout_q <= (timeout_q & ~clr) | set_timeout;
    end
  end

`ifdef EMMC_DDR_RX_LANE_ERR_EN
  logic [PW-1:0] lane_err_q;
  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) lane_err_q <= '0;
    else        lane_err_q <= (lane_err_q & {PW{~clr}}) | lane_set;
  end
  assign crc_lane_err_o = lane_err_q;
`endif

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign crc_err_o    = crc_err_q;
  assign end_err_o    = end_err_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_emmc_ddr_dat_rx.sv
// Directed bench for emmc_ddr_dat_rx: a 4-lane instance for the block scenarios, an 8-lane one for a 512-byte block.
`timescale 1ns/1ps
module tb_emmc_ddr_dat_rx;

  logic sd_clk = 1'b0;
  always #5 sd_clk = ~sd_clk;

  logic        rst_n;
  logic [3:0]  dat4;
  logic        start4, abort4;
  logic [11:0] blk4;
  logic [7:0]  d4;
  logic        v4, busy4, done4, crc4, end4, to4;
  logic [7:0]  dat8;
  logic        start8, abort8;
  logic [11:0] blk8;
  logic [15:0] d8;
  logic        v8, busy8, done8, crc8, end8, to8;
`ifdef EMMC_DDR_RX_LANE_ERR_EN
  logic [7:0]  lane4;
  logic [15:0] lane8;
`endif

  emmc_ddr_dat_rx #(.DAT_W(4), .BLK_W(12), .TIMEOUT_CYC(1024)) dut4 (
    .sd_clk(sd_clk), .rst_n(rst_n), .dat_i(dat4), .start_i(start4), .abort_i(abort4),
    .blk_size_i(blk4), .data_o(d4), .data_valid_o(v4), .busy_o(busy4), .done_o(done4),
    .crc_err_o(crc4), .end_err_o(end4), .timeout_o(to4)
`ifdef EMMC_DDR_RX_LANE_ERR_EN
    , .crc_lane_err_o(lane4)
`endif
  );

  emmc_ddr_dat_rx #(.DAT_W(8), .BLK_W(12), .TIMEOUT_CYC(1024)) dut8 (
    .sd_clk(sd_clk), .rst_n(rst_n), .dat_i(dat8), .start_i(start8), .abort_i(abort8),
    .blk_size_i(blk8), .data_o(d8), .data_valid_o(v8), .busy_o(busy8), .done_o(done8),
    .crc_err_o(crc8), .end_err_o(end8), .timeout_o(to8)
`ifdef EMMC_DDR_RX_LANE_ERR_EN
    , .crc_lane_err_o(lane8)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  tx4 [0:3];
  logic [15:0] tx8 [0:255];
  logic [7:0]  rx4_q [$];
  logic [15:0] rx8_q [$];
  int done4_n = 0;
  int done8_n = 0;

  always @(negedge sd_clk) begin
    if (v4) rx4_q.push_back(d4);
    if (done4) done4_n++;
    if (v8) rx8_q.push_back(d8);
    if (done8) done8_n++;
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if (c[15] ^ b) r = r ^ 16'h1021;
    return r;
  endfunction

  // Stimulus phase: every task starts and ends 1ns after a falling edge.
  task automatic send_pair4(input logic [3:0] r, input logic [3:0] f);
    dat4 = r;
    @(posedge sd_clk); #1 dat4 = f;
    @(negedge sd_clk); #1;
  endtask

  task automatic send_pair8(input logic [7:0] r, input logic [7:0] f);
    dat8 = r;
    @(posedge sd_clk); #1 dat8 = f;
    @(negedge sd_clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sd_clk); #1;
    end
  endtask

  task automatic arm4(input logic [11:0] blk);
    start4 = 1'b1; blk4 = blk;
    send_pair4(4'hF, 4'hF);
    start4 = 1'b0;
  endtask

  task automatic send_block4(input int n, input logic [7:0] flip, input logic [7:0] endp);
    logic [15:0] c [0:7];
    logic [7:0]  p;
    for (int j = 0; j < 8; j++) c[j] = 16'h0000;
    send_pair4(4'hF, 4'hF);
    send_pair4(4'h0, 4'h0);
    for (int i = 0; i < n; i++) begin
      p = tx4[i];
      for (int j = 0; j < 8; j++) c[j] = crc_step(c[j], p[j]);
      send_pair4(p[7:4], p[3:0]);
    end
    for (int k = 15; k >= 0; k--) begin
      for (int j = 0; j < 8; j++) p[j] = c[j][k];
      if (k == 15) p = p ^ flip;
      send_pair4(p[7:4], p[3:0]);
    end
    send_pair4(endp[7:4], endp[3:0]);
    for (int i = 0; i < 3; i++) send_pair4(4'hF, 4'hF);
  endtask

  task automatic send_block8(input int n, input logic [15:0] endp);
    logic [15:0] c [0:15];
    logic [15:0] p;
    for (int j = 0; j < 16; j++) c[j] = 16'h0000;
    send_pair8(8'hFF, 8'hFF);
    send_pair8(8'h00, 8'h00);
    for (int i = 0; i < n; i++) begin
      p = tx8[i];
      for (int j = 0; j < 16; j++) c[j] = crc_step(c[j], p[j]);
      send_pair8(p[15:8], p[7:0]);
    end
    for (int k = 15; k >= 0; k--) begin
      for (int j = 0; j < 16; j++) p[j] = c[j][k];
      send_pair8(p[15:8], p[7:0]);
    end
    send_pair8(endp[15:8], endp[7:0]);
    for (int i = 0; i < 3; i++) send_pair8(8'hFF, 8'hFF);
  endtask

  task automatic wait_done4(input int base, input int limit);
    for (int t = 0; t < limit && done4_n == base; t++) idle(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dat4 = 4'hF; dat8 = 8'hFF;
    start4 = 0; abort4 = 0; blk4 = '0; start8 = 0; abort8 = 0; blk8 = '0;
    idle(3);
    total++;
    if ({d4, v4, busy4, done4, crc4, end4, to4} !== 14'h0) begin
      bad++; $display("FAIL reset4: outputs=%h required=0", {d4, v4, busy4, done4, crc4, end4, to4});
    end
    total++;
    if ({d8, v8, busy8, done8, crc8, end8, to8} !== 22'h0) begin
      bad++; $display("FAIL reset8: outputs=%h required=0", {d8, v8, busy8, done8, crc8, end8, to8});
    end
    rst_n = 1'b1;
    idle(4);
    $display("reset: outputs clear");
  endtask

  task automatic test_good_block();
    int bv = rx4_q.size();
    int bd = done4_n;
    arm4(12'd4);
    send_block4(4, 8'h00, 8'hFF);
    wait_done4(bd, 50);
    idle(2);
    total++;
    if (rx4_q.size() - bv !== 4) begin
      bad++; $display("FAIL good_count: valid=%0d required=4", rx4_q.size() - bv);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (rx4_q[bv+i] !== tx4[i]) begin
          bad++; $display("FAIL good_data[%0d]: got=%h required=%h", i, rx4_q[bv+i], tx4[i]);
        end
      end
    end
    total++;
    if (done4_n - bd !== 1) begin bad++; $display("FAIL good_done: pulses=%0d required=1", done4_n - bd); end
    total++;
    if ({crc4, end4, to4, busy4} !== 4'b0000) begin
      bad++; $display("FAIL good_flags: crc/end/to/busy=%b required=0000", {crc4, end4, to4, busy4});
    end
`ifdef EMMC_DDR_RX_LANE_ERR_EN
    total++;
    if (lane4 !== 8'h00) begin bad++; $display("FAIL good_lane: got=%b required=00000000", lane4); end
`endif
    $display("good block: valid=%0d done=%0d crc=%b end=%b", rx4_q.size() - bv, done4_n - bd, crc4, end4);
  endtask

  task automatic test_crc_error();
    int bv = rx4_q.size();
    int bd = done4_n;
    arm4(12'd4);
    send_block4(4, 8'h04, 8'hFF);
    wait_done4(bd, 50);
    idle(2);
    total++;
    if (crc4 !== 1'b1) begin bad++; $display("FAIL crc_err: got=%b required=1", crc4); end
    total++;
    if (end4 !== 1'b0) begin bad++; $display("FAIL crc_end: got=%b required=0", end4); end
    total++;
    if (rx4_q.size() - bv !== 4 || done4_n - bd !== 1) begin
      bad++; $display("FAIL crc_counts: valid=%0d done=%0d required 4/1", rx4_q.size() - bv, done4_n - bd);
    end
`ifdef EMMC_DDR_RX_LANE_ERR_EN
    total++;
    if (lane4 !== 8'b0000_0100) begin bad++; $display("FAIL crc_lane: got=%b required=00000100", lane4); end
`endif
    $display("crc error block: crc=%b end=%b", crc4, end4);
  endtask

  task automatic test_timeout();
    int bv = rx4_q.size();
    int bd = done4_n;
    dat4 = 4'hF;
    arm4(12'd4);
    idle(1000);
    total++;
    if ({to4, busy4} !== 2'b01) begin
      bad++; $display("FAIL timeout_early: to/busy=%b required=01", {to4, busy4});
    end
    wait_done4(bd, 100);
    idle(2);
    total++;
    if (to4 !== 1'b1) begin bad++; $display("FAIL timeout_flag: got=%b required=1", to4); end
    total++;
    if (done4_n - bd !== 1) begin bad++; $display("FAIL timeout_done: pulses=%0d required=1", done4_n - bd); end
    total++;
    if (rx4_q.size() - bv !== 0) begin bad++; $display("FAIL timeout_valid: valid=%0d required=0", rx4_q.size() - bv); end
    total++;
    if ({crc4, end4} !== 2'b00) begin bad++; $display("FAIL timeout_crc: crc/end=%b required=00", {crc4, end4}); end
    $display("timeout: to=%b done=%0d", to4, done4_n - bd);
  endtask

  task automatic test_end_error();
    int bv = rx4_q.size();
    int bd = done4_n;
    arm4(12'd4);
    send_block4(4, 8'h00, 8'hEF);
    wait_done4(bd, 50);
    idle(2);
    total++;
    if ({end4, crc4, to4} !== 3'b100) begin
      bad++; $display("FAIL end_flags: end/crc/to=%b required=100", {end4, crc4, to4});
    end
    total++;
    if (done4_n - bd !== 1) begin bad++; $display("FAIL end_done: pulses=%0d required=1", done4_n - bd); end
    total++;
    if (rx4_q.size() - bv !== 4) begin bad++; $display("FAIL end_valid: valid=%0d required=4", rx4_q.size() - bv); end
    $display("end error block: end=%b crc=%b", end4, crc4);
  endtask

  task automatic test_abort();
    int bv = rx4_q.size();
    int bd = done4_n;
    arm4(12'd4);
    send_pair4(4'hF, 4'hF);
    send_pair4(4'h0, 4'h0);
    for (int i = 0; i < 4; i++) send_pair4(tx4[i][7:4], tx4[i][3:0]);
    abort4 = 1'b1;
    send_pair4(4'hF, 4'hF);
    abort4 = 1'b0;
    total++;
    if (busy4 !== 1'b0) begin bad++; $display("FAIL abort_busy: got=%b required=0", busy4); end
    idle(30);
    total++;
    if (rx4_q.size() - bv !== 2) begin
      bad++; $display("FAIL abort_valid: valid=%0d required=2", rx4_q.size() - bv);
    end else begin
      total++;
      if ({rx4_q[bv], rx4_q[bv+1]} !== 16'h1234) begin
        bad++; $display("FAIL abort_data: got=%h%h required=1234", rx4_q[bv], rx4_q[bv+1]);
      end
    end
    total++;
    if (done4_n - bd !== 0) begin bad++; $display("FAIL abort_done: pulses=%0d required=0", done4_n - bd); end
    total++;
    if ({crc4, end4, to4} !== 3'b000) begin
      bad++; $display("FAIL abort_flags: crc/end/to=%b required=000", {crc4, end4, to4});
    end
    $display("abort: valid=%0d done=%0d busy=%b", rx4_q.size() - bv, done4_n - bd, busy4);
  endtask

  task automatic test_blk_zero();
    int bv = rx4_q.size();
    int bd = done4_n;
    start4 = 1'b1; blk4 = 12'd0;
    idle(1);
    total++;
    if ({done4, busy4} !== 2'b11) begin bad++; $display("FAIL zero_done: done/busy=%b required=11", {done4, busy4}); end
    idle(1);
    total++;
    if ({done4, busy4} !== 2'b00) begin
      bad++; $display("FAIL zero_restart: done/busy=%b required=00 (start held through done)", {done4, busy4});
    end
    start4 = 1'b0;
    idle(3);
    total++;
    if (rx4_q.size() - bv !== 0 || done4_n - bd !== 1 || {crc4, end4, to4} !== 3'b000) begin
      bad++; $display("FAIL zero_summary: valid=%0d done=%0d flags=%b required 0/1/000",
                      rx4_q.size() - bv, done4_n - bd, {crc4, end4, to4});
    end
    $display("zero-size block: done=%0d", done4_n - bd);
  endtask

  task automatic test_reset_mid();
    arm4(12'd4);
    send_pair4(4'hF, 4'hF);
    send_pair4(4'h0, 4'h0);
    for (int i = 0; i < 4; i++) send_pair4(tx4[i][7:4], tx4[i][3:0]);
    for (int i = 0; i < 6; i++) send_pair4(4'hF, 4'hF);
    total++;
    if (busy4 !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got=%b required=1", busy4); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({d4, v4, busy4, done4, crc4, end4, to4} !== 14'h0) begin
      bad++; $display("FAIL midrst_outputs: got=%h required=0", {d4, v4, busy4, done4, crc4, end4, to4});
    end
    idle(2);
    rst_n = 1'b1;
    idle(4);
    $display("reset in CRC phase: busy=%b data=%h", busy4, d4);
  endtask

  task automatic test_wide_block();
    int bv = rx8_q.size();
    int bd = done8_n;
    int errs = 0;
    start8 = 1'b1; blk8 = 12'd512;
    send_pair8(8'hFF, 8'hFF);
    start8 = 1'b0;
    send_block8(256, 16'hFFFF);
    for (int t = 0; t < 50 && done8_n == bd; t++) idle(1);
    idle(2);
    total++;
    if (rx8_q.size() - bv !== 256) begin
      bad++; $display("FAIL wide_count: valid=%0d required=256", rx8_q.size() - bv);
    end else begin
      for (int i = 0; i < 256; i++) begin
        total++;
        if (rx8_q[bv+i] !== tx8[i]) begin
          bad++; errs++;
          $display("FAIL wide_data[%0d]: got=%h required=%h", i, rx8_q[bv+i], tx8[i]);
        end
      end
    end
    total++;
    if (done8_n - bd !== 1) begin bad++; $display("FAIL wide_done: pulses=%0d required=1", done8_n - bd); end
    total++;
    if ({crc8, end8, to8, busy8} !== 4'b0000) begin
      bad++; $display("FAIL wide_flags: crc/end/to/busy=%b required=0000", {crc8, end8, to8, busy8});
    end
`ifdef EMMC_DDR_RX_LANE_ERR_EN
    total++;
    if (lane8 !== 16'h0000) begin bad++; $display("FAIL wide_lane: got=%h required=0000", lane8); end
`endif
    $display("8-lane 512-byte block: valid=%0d data_errs=%0d done=%0d", rx8_q.size() - bv, errs, done8_n - bd);
  endtask

  initial begin
    tx4[0] = 8'h12; tx4[1] = 8'h34; tx4[2] = 8'h56; tx4[3] = 8'h78;
    for (int i = 0; i < 256; i++) tx8[i] = 16'(i * 40503 + 12345);
    test_reset();
    test_good_block();
    test_crc_error();
    test_timeout();
    test_end_error();
    test_abort();
    test_good_block();
    test_blk_zero();
    test_reset_mid();
    test_wide_block();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
